// File: rtl/par_circular_fifo.sv
// par_circular_fifo
// -----------------------------------------------------------------------------
// Purpose : circular-buffer FIFO with asymmetric parallelism. Each accepted
//           write beat stores PAR_WRITE words. Each accepted read beat
//           retires PAR_READ words. The head words are presented
//           combinationally on dout (show-ahead). The buffer holds MEM_SIZE
//           words; MEM_SIZE need not be a power of two.
//
// Ports   : clk    in   clock; all state changes on the rising edge
//           rstn   in   synchronous active-low reset (also zeroes storage)
//           clear  in   synchronous flush (pointers/count only)
//           wen    in   write request, accepted when ready
//           ren    in   read request, accepted when valid
//           din    in   PAR_WRITE words, slice [SIZE-1:0] enqueued first
//           full   out  count == MEM_SIZE
//           empty  out  count == 0
//           ready  out  free space >= PAR_WRITE
//           valid  out  count >= PAR_READ
//           dout   out  PAR_READ head words, slice [SIZE-1:0] oldest; zero
//                       when !valid
//
// Optional: define FIFO_STATUS_EN to add these outputs:
//           level  out  current occupancy
//           ovf    out  sticky: write requested while !ready
//           udf    out  sticky: read requested while !valid
//           Reset or clear zeroes ovf and udf.
// -----------------------------------------------------------------------------
module par_circular_fifo #(
  parameter int SIZE      = 16,
  parameter int MEM_SIZE  = 8,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear,
  input  logic                      wen,
  input  logic                      ren,
  input  logic [PAR_WRITE*SIZE-1:0] din,
`ifdef FIFO_STATUS_EN
  output logic [$clog2(MEM_SIZE+1)-1:0] level,
  output logic                      ovf,
  output logic                      udf,
`endif
  output logic                      full,
  output logic                      empty,
  output logic                      ready,
  output logic                      valid,
  output logic [PAR_READ*SIZE-1:0]  dout
);

  localparam int CW = $clog2(MEM_SIZE + 1);
  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(MEM_SIZE);
  localparam logic [CW-1:0] PW_C    = CW'(PAR_WRITE);
  localparam logic [CW-1:0] PR_C    = CW'(PAR_READ);
  localparam logic [IW:0]   DEPTH_I = (IW+1)'(MEM_SIZE);

  logic [SIZE-1:0] mem [MEM_SIZE];
  logic [IW-1:0]   wp;
  logic [IW-1:0]   rp;
  logic [CW-1:0]   count;

  logic wr_acc;
  logic rd_acc;

  // base is below MEM_SIZE and off is at most MEM_SIZE, so the sum is below
  // 2*MEM_SIZE and one conditional subtraction is an exact modulo.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input logic [IW:0]   off);
    logic [IW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= DEPTH_I) begin
      sum = sum - DEPTH_I;
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction

  // Status outputs are derived from the registered occupancy.
  assign full   = (count == DEPTH_C);
  assign empty  = (count == CW'(0));
  assign ready  = ((DEPTH_C - count) >= PW_C);
  assign valid  = (count >= PR_C);

  // Acceptance uses the pre-edge ready/valid, so a read and a write in the
  // same cycle are judged independently.
  assign wr_acc = wen && ready;
  assign rd_acc = ren && valid;

  // Storage, pointers and occupancy: reset > clear > read/write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
          mem[wrap_idx(wp, (IW+1)'(i))] <= din[i*SIZE +: SIZE];
        end
        wp <= wrap_idx(wp, (IW+1)'(PAR_WRITE));
      end
      if (rd_acc) begin
        rp <= wrap_idx(rp, (IW+1)'(PAR_READ));
      end
      count <= count + (wr_acc ? PW_C : CW'(0)) - (rd_acc ? PR_C : CW'(0));
    end
  end

  // Show-ahead head words; dout is zero whenever it is not valid.
  always_comb begin
    dout = '0;
    if (valid) begin
      for (int j = 0; j < PAR_READ; j++) begin
        dout[j*SIZE +: SIZE] = mem[wrap_idx(rp, (IW+1)'(j))];
      end
    end else begin
      dout = '0;
    end
  end

`ifdef FIFO_STATUS_EN
  assign level = count;

  // Sticky overflow/underflow flags; reset and clear win over setting.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wen && !ready) begin
        ovf <= 1'b1;
      end
      if (ren && !valid) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_par_circular_fifo.sv
// Scoreboard bench for par_circular_fifo (SIZE=16, MEM_SIZE=8, PAR_WRITE=4,
// PAR_READ=1). The stimulus pushes the words it expects the FIFO to accept.
// A negedge monitor pops and compares dout whenever a read is accepted.
module tb_par_circular_fifo;

  localparam int SIZE = 16;
  localparam int MEM_SIZE = 8;
  localparam int PAR_WRITE = 4;
  localparam int PAR_READ = 1;

  logic                      clk;
  logic                      rstn;
  logic                      clear;
  logic                      wen;
  logic                      ren;
  logic [PAR_WRITE*SIZE-1:0] din;
  logic                      full;
  logic                      empty;
  logic                      ready;
  logic                      valid;
  logic [PAR_READ*SIZE-1:0]  dout;
`ifdef FIFO_STATUS_EN
  logic [$clog2(MEM_SIZE+1)-1:0] level;
  logic                      ovf;
  logic                      udf;
`endif

  int checks = 0;
  int failures = 0;
  logic [SIZE-1:0] exp_q[$];

  par_circular_fifo #(
    .SIZE(SIZE), .MEM_SIZE(MEM_SIZE), .PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .wen(wen), .ren(ren), .din(din),
`ifdef FIFO_STATUS_EN
    .level(level), .ovf(ovf), .udf(udf),
`endif
    .full(full), .empty(empty), .ready(ready), .valid(valid), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a write beat; if the bench expects acceptance, queue its words in order.
  task automatic write_beat(input logic [15:0] w3, input logic [15:0] w2,
                            input logic [15:0] w1, input logic [15:0] w0,
                            input bit accepted, input bit with_read);
    din = {w3, w2, w1, w0};
    wen = 1'b1;
    ren = with_read;
    if (accepted) begin
      exp_q.push_back(w0);
      exp_q.push_back(w1);
      exp_q.push_back(w2);
      exp_q.push_back(w3);
    end
    step();
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic read_beats(input int n);
    ren = 1'b1;
    repeat (n) step();
    ren = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_dout"},  32'(dout),  32'd0);
  endtask

  // Monitor: every accepted read must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn && !clear && ren && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected: got %0d expected no data", dout);
      end else begin
        check("read_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rstn = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    // 1. reset
    step();
    rstn = 1'b1;
    check_idle("reset");

    // 2. first beat {12,8,1,5}: oldest word is 5
    write_beat(16'd12, 16'd8, 16'd1, 16'd5, 1'b1, 1'b0);
    check("w1_valid", 32'(valid), 32'd1);
    check("w1_dout",  32'(dout),  32'd5);
    check("w1_ready", 32'(ready), 32'd1);
    check("w1_empty", 32'(empty), 32'd0);
`ifdef FIFO_STATUS_EN
    check("w1_level", 32'(level), 32'd4);
`endif

    // 3. fill, then a write while full is ignored
    write_beat(16'd120, 16'd130, 16'd150, 16'd170, 1'b1, 1'b0);
    check("fill_full",  32'(full),  32'd1);
    check("fill_ready", 32'(ready), 32'd0);
    write_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0);
    check("ovfw_full", 32'(full), 32'd1);
    check("ovfw_dout", 32'(dout), 32'd5);
`ifdef FIFO_STATUS_EN
    check("ovfw_ovf", 32'(ovf), 32'd1);
    check("ovfw_level", 32'(level), 32'd8);
`endif

    // 4. drain with ren held; ready returns after the 4th read
    ren = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 8) ren = 1'b0;
      check($sformatf("drain_ready_%0d", k), 32'(ready), (k >= 4) ? 32'd1 : 32'd0);
    end
    check_idle("drained");

    // 5. wrap and concurrency
    write_beat(16'h13, 16'h12, 16'h11, 16'h10, 1'b1, 1'b0);  // wp 0->4
    read_beats(3);                                            // rp 0->3, count 1
    write_beat(16'h23, 16'h22, 16'h21, 16'h20, 1'b1, 1'b0);  // wp 4->0, count 5
    check("c5_ready", 32'(ready), 32'd0);
    read_beats(1);                                            // count 4
    check("c4_ready", 32'(ready), 32'd1);
    write_beat(16'h33, 16'h32, 16'h31, 16'h30, 1'b1, 1'b1);  // indices 0..3, count 7
    check("c7_full",  32'(full),  32'd0);
    check("c7_ready", 32'(ready), 32'd0);
    check("c7_dout",  32'(dout),  32'h21);
`ifdef FIFO_STATUS_EN
    check("c7_level", 32'(level), 32'd7);
`endif
    write_beat(16'h43, 16'h42, 16'h41, 16'h40, 1'b0, 1'b1);  // write refused, read done
    check("c6_valid", 32'(valid), 32'd1);
    check("c6_dout",  32'(dout),  32'h22);
    read_beats(6);                                            // rp wraps 7 -> 0
    check_idle("wrap_drained");
    read_beats(1);                                            // read while empty ignored
    check_idle("empty_read");
`ifdef FIFO_STATUS_EN
    check("empty_read_udf", 32'(udf), 32'd1);
`endif

    // 6. clear with a simultaneous write discards everything
    write_beat(16'h53, 16'h52, 16'h51, 16'h50, 1'b1, 1'b0);
    clear = 1'b1;
    write_beat(16'h63, 16'h62, 16'h61, 16'h60, 1'b0, 1'b0);
    clear = 1'b0;
    exp_q.delete();
    check_idle("clear");
`ifdef FIFO_STATUS_EN
    check("clear_ovf", 32'(ovf), 32'd0);
    check("clear_udf", 32'(udf), 32'd0);
    check("clear_level", 32'(level), 32'd0);
`endif

    // reset mid-stream with a write in the same cycle
    write_beat(16'h73, 16'h72, 16'h71, 16'h70, 1'b1, 1'b0);
    rstn = 1'b0;
    write_beat(16'h83, 16'h82, 16'h81, 16'h80, 1'b0, 1'b0);
    rstn = 1'b1;
    exp_q.delete();
    check_idle("midreset");

    // operation after reset starts from index 0 again
    write_beat(16'h93, 16'h92, 16'h91, 16'h90, 1'b1, 1'b0);
    check("post_dout", 32'(dout), 32'h90);
    read_beats(4);
    check_idle("post_drain");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_words: got %0d expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
